// File: rtl/count_ctrl_pkg.sv
// count_ctrl_pkg: shared definitions for the count_ctrl sequencer.
//   ST_IDLE / ST_RUN / ST_DONE : FSM state encodings (2-bit)
//   DEF_WIDTH, DEF_PRESCALE_W  : default counter and prescaler widths
package count_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int unsigned DEF_WIDTH      = 4;
    localparam int unsigned DEF_PRESCALE_W = 8;

endpackage

// File: rtl/count_ctrl_prescaler.sv
// count_ctrl_prescaler: tick divider, one tick every presc+1 clocks.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clr       - restart the divider phase (next tick after presc+1 clocks)
//   presc     - divide value (already sampled by the parent)
//   tick      - combinational tick strobe
module count_ctrl_prescaler
    import count_ctrl_pkg::*;
#(
    parameter int unsigned PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] presc,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] cnt_d;

    assign tick = (cnt_q == presc);

    // Wrap on tick; clr re-aligns the phase regardless of tick.
    always_comb begin
        cnt_d = cnt_q + PRESCALE_W'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/count_ctrl.sv
// count_ctrl: start/stop sequencer for an up/down interval counter with
// optional autoreload. Optional prescaler enabled by COUNT_CTRL_PRESCALE_EN.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   start       - start request (IDLE only); samples dir/autoreload/limit
//   stop        - abort (RUN only), wins over terminal
//   dir         - 1 = up (0 -> limit), 0 = down (limit -> 0)
//   autoreload  - reload and continue at terminal
//   limit       - terminal (up) / start (down) value
//   presc       - tick divider (COUNT_CTRL_PRESCALE_EN only)
//   count       - current count
//   busy        - high in RUN
//   done        - one-cycle pulse per completed pass
//   tc          - combinational: RUN and count at terminal
module count_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
`ifdef COUNT_CTRL_PRESCALE_EN
   ,parameter int unsigned PRESCALE_W = DEF_PRESCALE_W
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  dir,
    input  logic                  autoreload,
    input  logic [WIDTH-1:0]      limit,
`ifdef COUNT_CTRL_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] presc,
`endif
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  done,
    output logic                  tc
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             dir_q, dir_d;
    logic             auto_q, auto_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] reload_val;
    logic             at_term;
    logic             tick;

    assign term       = dir_q ? limit_q : '0;
    assign reload_val = dir_q ? '0 : limit_q;
    assign at_term    = (count_q == term);

`ifdef COUNT_CTRL_PRESCALE_EN
    logic [PRESCALE_W-1:0] presc_q;
    logic                  presc_clr;

    // Phase restarts on the start edge and on every autoreload.
    assign presc_clr = ((state_q == ST_IDLE) && start) ||
                       ((state_q == ST_RUN) && !stop && tick && at_term && auto_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else if ((state_q == ST_IDLE) && start) begin
            presc_q <= presc;
        end
    end

    count_ctrl_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clr   (presc_clr),
        .presc (presc_q),
        .tick  (tick)
    );
`else
    assign tick = 1'b1;
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        limit_d = limit_q;
        dir_d   = dir_q;
        auto_d  = auto_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    dir_d   = dir;
                    auto_d  = autoreload;
                    limit_d = limit;
                    count_d = dir ? '0 : limit;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (at_term) begin
                        done_d = 1'b1;
                        if (auto_q) begin
                            count_d = reload_val;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else if (dir_q) begin
                        count_d = count_q + WIDTH'(1);
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            limit_q <= '0;
            dir_q   <= 1'b0;
            auto_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
            dir_q   <= dir_d;
            auto_q  <= auto_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign tc    = (state_q == ST_RUN) && at_term;

endmodule

// File: tb/tb_count_ctrl.sv
// tb_count_ctrl: vector-table bench for count_ctrl with an expected-value queue.
module tb_count_ctrl;
    import count_ctrl_pkg::*;

    localparam int unsigned W  = DEF_WIDTH;
    localparam int unsigned PW = DEF_PRESCALE_W;

    typedef struct {
        logic          rst;
        logic          start;
        logic          stop;
        logic          dir;
        logic          arl;
        logic [W-1:0]  limit;
        logic [PW-1:0] presc;
        logic [W-1:0]  cnt;
        logic          busy;
        logic          done;
        logic          tc;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic         stop;
    logic         dir;
    logic         autoreload;
    logic [W-1:0] limit;
`ifdef COUNT_CTRL_PRESCALE_EN
    logic [PW-1:0] presc;
`endif
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    logic         tc;

    int checks = 0;
    int errors = 0;

    vec_t vecs[$];
    vec_t sb[$];

    count_ctrl #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .dir        (dir),
        .autoreload (autoreload),
        .limit      (limit),
`ifdef COUNT_CTRL_PRESCALE_EN
        .presc      (presc),
`endif
        .count      (count),
        .busy       (busy),
        .done       (done),
        .tc         (tc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Record: inputs for one edge, then outputs expected just after that edge.
    task automatic add(input int r, input int s, input int p, input int d, input int a,
                       input int lim, input int pr,
                       input int c, input int b, input int dn, input int t);
        vec_t v;
        v.rst   = 1'(r);
        v.start = 1'(s);
        v.stop  = 1'(p);
        v.dir   = 1'(d);
        v.arl   = 1'(a);
        v.limit = W'(lim);
        v.presc = PW'(pr);
        v.cnt   = W'(c);
        v.busy  = 1'(b);
        v.done  = 1'(dn);
        v.tc    = 1'(t);
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t e;
        clk = 1'b0; rst = 1'b1; start = 1'b0; stop = 1'b0;
        dir = 1'b0; autoreload = 1'b0; limit = '0;
`ifdef COUNT_CTRL_PRESCALE_EN
        presc = '0;
`endif
        //  rst st sp dr ar lim pr | cnt busy done tc
        // reset
        add(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        // up, one-shot, L=3
        add(0, 1, 0, 1, 0, 3, 0,   0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 3, 0,   1, 1, 0, 0);
        add(0, 0, 0, 1, 0, 3, 0,   2, 1, 0, 0);
        add(0, 0, 0, 1, 0, 3, 0,   3, 1, 0, 1);
        add(0, 0, 0, 1, 0, 3, 0,   3, 0, 1, 0);
        add(0, 0, 0, 1, 0, 3, 0,   3, 0, 0, 0);
        add(0, 0, 0, 1, 0, 3, 0,   3, 0, 0, 0);
        // up L=2; start held and dir/limit changed during RUN and DONE
        add(0, 1, 0, 1, 0, 2, 0,   0, 1, 0, 0);
        add(0, 1, 0, 0, 1, 7, 0,   1, 1, 0, 0);
        add(0, 1, 0, 0, 1, 7, 0,   2, 1, 0, 1);
        add(0, 1, 0, 0, 1, 7, 0,   2, 0, 1, 0);
        add(0, 1, 0, 0, 1, 7, 0,   2, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,   2, 0, 0, 0);
        // down, autoreload, L=2, stop at count 0
        add(0, 1, 0, 0, 1, 2, 0,   2, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0,   2, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0,   2, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1);
        add(0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        // down, one-shot, L=3
        add(0, 1, 0, 0, 0, 3, 0,   3, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        // limit=0 up then down, one-shot
        add(0, 1, 0, 1, 0, 0, 0,   0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 5, 0,   0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 5, 0,   0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0,   0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 5, 0,   0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 5, 0,   0, 0, 0, 0);
        // reset mid-RUN (up L=9 at count 4), then a normal up L=1 run
        add(0, 1, 0, 1, 0, 9, 0,   0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 9, 0,   1, 1, 0, 0);
        add(0, 0, 0, 1, 0, 9, 0,   2, 1, 0, 0);
        add(0, 0, 0, 1, 0, 9, 0,   3, 1, 0, 0);
        add(0, 0, 0, 1, 0, 9, 0,   4, 1, 0, 0);
        add(1, 0, 0, 1, 0, 9, 0,   0, 0, 0, 0);
        add(1, 0, 0, 1, 0, 9, 0,   0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 9, 0,   0, 0, 0, 0);
        add(0, 1, 0, 1, 0, 1, 0,   0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 1, 0,   1, 1, 0, 1);
        add(0, 0, 0, 1, 0, 1, 0,   1, 0, 1, 0);
        add(0, 0, 0, 1, 0, 1, 0,   1, 0, 0, 0);
`ifdef COUNT_CTRL_PRESCALE_EN
        // presc=2, up L=2: count changes at E0+3, E0+6; DONE at E0+9
        add(0, 1, 0, 1, 0, 2, 2,   0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 2, 0,   0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 2, 0,   0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 2, 0,   1, 1, 0, 0);
        add(0, 0, 0, 1, 0, 2, 0,   1, 1, 0, 0);
        add(0, 0, 0, 1, 0, 2, 0,   1, 1, 0, 0);
        add(0, 0, 0, 1, 0, 2, 0,   2, 1, 0, 1);
        add(0, 0, 0, 1, 0, 2, 0,   2, 1, 0, 1);
        add(0, 0, 0, 1, 0, 2, 0,   2, 1, 0, 1);
        add(0, 0, 0, 1, 0, 2, 0,   2, 0, 1, 0);
        add(0, 0, 0, 1, 0, 2, 0,   2, 0, 0, 0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst        = vecs[i].rst;
            start      = vecs[i].start;
            stop       = vecs[i].stop;
            dir        = vecs[i].dir;
            autoreload = vecs[i].arl;
            limit      = vecs[i].limit;
`ifdef COUNT_CTRL_PRESCALE_EN
            presc      = vecs[i].presc;
`endif
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard v%0d: queue empty", i);
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d count", i), 32'(count), 32'(e.cnt));
                chk($sformatf("v%0d busy", i),  32'(busy),  32'(e.busy));
                chk($sformatf("v%0d done", i),  32'(done),  32'(e.done));
                chk($sformatf("v%0d tc", i),    32'(tc),    32'(e.tc));
            end
        end

        // Asynchronous reset between clock edges: outputs clear before next edge.
        @(negedge clk);
        start = 1'b1; stop = 1'b0; dir = 1'b1; autoreload = 1'b0; limit = W'(9);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        chk("async pre-reset count", 32'(count), 32'd4);
        chk("async pre-reset busy",  32'(busy),  32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("async reset count", 32'(count), 32'd0);
        chk("async reset busy",  32'(busy),  32'd0);
        chk("async reset tc",    32'(tc),    32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("async reset done", 32'(done), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post-reset count", 32'(count), 32'd0);
        chk("post-reset busy",  32'(busy),  32'd0);
        chk("post-reset done",  32'(done),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_ctrl.md
# count_ctrl

Synchronous sequencer for an N-bit event/interval counter: accepts a start request, loads a start value, counts up or down toward a programmed limit, and signals completion. It can stop after one pass or reload and run again. It replaces free-running ripple chains wherever software or another block must start, stop and observe a count. All outputs change on one clock edge.

## Interface

Parameters
- WIDTH, 4, counter and limit width in bits (≥1)
- PRESCALE_W, 8, prescaler width; used only when COUNT_CTRL_PRESCALE_EN is defined

Ports
- clk  input  1  single clock; all state updates on posedge
- rst  input  1  asynchronous, active-high reset; clears all state immediately
- start  input  1  level-sampled start request; honoured only in IDLE
- stop  input  1  abort request; honoured only in RUN
- dir  input  1  1 = count up, 0 = count down; sampled with start
- autoreload  input  1  1 = reload and continue at terminal; sampled with start
- limit  input  WIDTH  terminal value (up) / start value (down); sampled with start
- presc  input  PRESCALE_W  tick divider; present only with COUNT_CTRL_PRESCALE_EN
- count  output  WIDTH  current count
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse per completed pass
- tc  output  1  combinational: RUN and count equals current terminal value

## Operation

- Reset values: state = IDLE, count = 0, busy = 0, done = 0, tc = 0. The prescaler and all sampled registers (dir_q, auto_q, limit_q) are 0.
- States:
  - IDLE: count holds its last value. start=1 → RUN. Load dir_q, auto_q, limit_q and count = (dir ? 0 : limit).
  - RUN: on each tick, count moves toward the terminal value (up: limit_q; down: 0).
    - Tick with count == terminal and auto_q=1: count reloads its start value, done pulses, state stays RUN.
    - Tick with count == terminal and auto_q=0: → DONE, count holds.
  - DONE: done=1 for exactly this cycle, then → IDLE unconditionally.
- Priority in RUN: stop beats terminal. stop=1 → IDLE, count holds, no done pulse, even when the terminal is reached in the same cycle.
- start is ignored in RUN and DONE. It is not queued.
- Changes to dir, limit or autoreload during RUN have no effect until the next start.
- Arithmetic is modulo 2^WIDTH but never wraps in practice, because the terminal is always reached first.
- limit=0:
  - Up: the terminal is reached at the first tick.
  - Down: the load value is 0, so the terminal is reached at the first tick.
- Reset asserted mid-RUN: state, count and outputs return to reset values asynchronously, and no done pulse is produced.

## Timing

- start sampled at edge E0: count holds its start value from E0, and busy=1 from E0.
- Without prescale, a tick occurs on every clock in RUN. The first count change is at E0+1.
- Up count, one-shot, limit L:
  - count reaches L at E0+L.
  - The terminal tick at E0+L+1 enters DONE, so done is high between E0+L+1 and E0+L+2.
  - IDLE is re-entered at E0+L+2, and busy drops at E0+L+1.
- Down count: symmetric with the same latency. Start at L, reach 0 at E0+L.
- Autoreload: the period is L+1 ticks. done pulses at each reload edge and busy stays high.
- stop sampled at edge Es: IDLE and busy=0 from Es.

## Configuration

- COUNT_CTRL_PRESCALE_EN defined:
  - The presc port exists, and a tick occurs once every presc+1 clocks in RUN.
  - The prescaler is cleared at the start edge and at each terminal reload, so the first tick is at E0+presc+1.
  - presc is sampled at start.
- Undefined: the presc port and prescaler logic are absent, and the tick is constant 1 in RUN.

## Structure

- Shared package/header count_ctrl_pkg holds the state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2, and the default WIDTH/PRESCALE_W.
- One sub-module, count_ctrl_prescaler (clk, rst, clr, presc, tick). It is instantiated only under COUNT_CTRL_PRESCALE_EN.

## Test plan

- Reset mid-RUN (up, L=9, rst at count=4) → count=0, busy=0, done never pulses; the next start works normally.
- Up, one-shot, L=3, start at E0 → count 0,1,2,3 at E0..E0+3; done high for exactly 1 cycle after E0+4; IDLE with count=3.
- Down, autoreload, L=2 → count 2,1,0,2,1,0…; done pulses every 3 clocks; busy stays 1 until stop. stop asserted when count=0 → IDLE, no done on that cycle.
- limit=0, both directions, one-shot → done pulses one cycle after the first tick; count stays 0.
- Start during RUN, and limit/dir changed during RUN → ignored; the sequence is unchanged.
- With COUNT_CTRL_PRESCALE_EN, presc=2, up L=2 → count changes every 3 clocks (E0+3, E0+6); done after the edge at E0+9.
